// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit family.
//   OP_W  : opcode width (3 bits, eight operations)
//   op_e  : named opcode encoding used by logic_op_comb and its callers
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOT_A  = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational bitwise logic operation, reusable by ALU blocks.
// Ports:
//   op : operation select (op_e)
//   a  : operand A, WIDTH bits
//   b  : operand B, WIDTH bits (unused for NOT_A and PASS_A)
//   y  : result, WIDTH bits (no width growth)
module logic_op_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_NOT_A:  y = ~a;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XOR:    y = a ^ b;
      OP_XNOR:   y = ~(a ^ b);
      OP_PASS_A: y = a;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a single valid/ready output stage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : operand beat present
//   in_ready   : stage can take a beat (empty, or being drained this cycle)
//   in_op      : opcode (logic_unit_pkg::op_e encoding)
//   in_a, in_b : operands
//   out_valid  : result beat present
//   out_ready  : consumer takes the result this cycle
//   out_y      : registered result
//   out_zero   : registered (out_y == 0)
//   out_parity : registered XOR-reduce of out_y; exists only when the
//                macro LOGIC_UNIT_PARITY_EN is defined
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_Y = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [WIDTH-1:0] res;
  logic             accept;
  logic             vld_p0;
  logic [WIDTH-1:0] y_p0;
  logic             zero_p0;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op (op_e'(in_op)),
    .a  (in_a),
    .b  (in_b),
    .y  (res)
  );

  // Ready depends only on the output register and out_ready, so no
  // combinational path exists from in_* to out_*.
  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;

  // ---- output stage p0 ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      y_p0    <= RESET_Y;
      zero_p0 <= (RESET_Y == '0);
    end else if (accept) begin
      vld_p0  <= 1'b1;
      y_p0    <= res;
      zero_p0 <= (res == '0);
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic par_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_p0 <= ^RESET_Y;
    end else if (accept) begin
      par_p0 <= ^res;
    end
  end

  assign out_parity = par_p0;
`endif

  assign out_valid = vld_p0;
  assign out_y     = y_p0;
  assign out_zero  = zero_p0;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe at WIDTH=8.
// Define LOGIC_UNIT_PARITY_EN on both bench and RTL to cover out_parity.
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_zero;
`ifdef LOGIC_UNIT_PARITY_EN
  logic         out_parity;
`endif

  int vectors    = 0;
  int miscompares = 0;
  logic rdy_seen;

  // Behavioural model of the single-entry output stage.
  logic         m_vld;
  logic [W-1:0] m_y;

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_zero  (out_zero)
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                          input logic [W-1:0] a, b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat, record in_ready before the edge, step to just after it.
  task automatic cycle(input logic r, input logic iv, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ordy);
    rst = r; in_valid = iv; in_op = op; in_a = a; in_b = b; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_y;
    logic         exp_zero;
  } vec_t;

  vec_t sweep[8];

  initial begin
    sweep[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    sweep[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    sweep[2] = '{3'd2, 8'hF0, 8'h3C, 8'h0F, 1'b0};
    sweep[3] = '{3'd3, 8'hF0, 8'h3C, 8'hCF, 1'b0};
    sweep[4] = '{3'd4, 8'hF0, 8'h3C, 8'h03, 1'b0};
    sweep[5] = '{3'd5, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    sweep[6] = '{3'd6, 8'hF0, 8'h3C, 8'h33, 1'b0};
    sweep[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset then idle
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    rst = 1'b0; #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_y", out_y, 8'h00);
    chk("reset_zero", out_zero, 1'b1);
    chk("reset_in_ready", in_ready, 1'b1);

    // Op sweep, back-to-back
    foreach (sweep[i]) begin
      cycle(1'b0, 1'b1, sweep[i].op, sweep[i].a, sweep[i].b, 1'b1);
      chk("sweep_ready", rdy_seen, 1'b1);
      chk("sweep_valid", out_valid, 1'b1);
      chk($sformatf("sweep_y_op%0d", i), out_y, sweep[i].exp_y);
      chk("sweep_zero", out_zero, sweep[i].exp_zero);
    end
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    chk("drain_valid", out_valid, 1'b0);

    // Backpressure
    cycle(1'b0, 1'b1, 3'd5, 8'hAA, 8'hAA, 1'b0);
    chk("bp_accept_valid", out_valid, 1'b1);
    chk("bp_accept_y", out_y, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 3'd1, 8'h11, 8'h22, 1'b0);
      chk("bp_in_ready", rdy_seen, 1'b0);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_y", out_y, 8'h00);
      chk("bp_hold_zero", out_zero, 1'b1);
    end
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 8'h22, 1'b1);
    chk("bp_release_ready", rdy_seen, 1'b1);
    chk("bp_release_valid", out_valid, 1'b1);
    chk("bp_release_y", out_y, 8'h33);

    // Simultaneous accept and drain
    cycle(1'b0, 1'b1, 3'd1, 8'h01, 8'h80, 1'b1);
    chk("simul_valid", out_valid, 1'b1);
    chk("simul_y", out_y, 8'h81);
    chk("simul_zero", out_zero, 1'b0);

    // Reset during a stall with an input beat offered
    cycle(1'b0, 1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0);
    chk("stall_y", out_y, 8'h81);
    cycle(1'b1, 1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0);
    chk("rst_stall_valid", out_valid, 1'b0);
    chk("rst_stall_y", out_y, 8'h00);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    chk("rst_no_accept", out_valid, 1'b0);

`ifdef LOGIC_UNIT_PARITY_EN
    cycle(1'b0, 1'b1, 3'd0, 8'h07, 8'hFF, 1'b1);
    chk("par_and_y", out_y, 8'h07);
    chk("par_and_parity", out_parity, 1'b1);
    cycle(1'b0, 1'b1, 3'd7, 8'h03, 8'h55, 1'b1);
    chk("par_pass_parity", out_parity, 1'b0);
`endif

    // Randomized traffic against the model
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    m_vld = 1'b0; m_y = 8'h00;
    for (int n = 0; n < 400; n++) begin
      logic         iv, ordy, acc;
      logic [2:0]   op;
      logic [W-1:0] a, b;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      op   = 3'($urandom);
      a    = 8'($urandom);
      b    = 8'($urandom);
      cycle(1'b0, iv, op, a, b, ordy);
      chk("rnd_in_ready", rdy_seen, !m_vld || ordy);
      acc = iv && (!m_vld || ordy);
      if (acc) begin
        m_vld = 1'b1;
        m_y   = ref_op(op, a, b);
      end else if (ordy) begin
        m_vld = 1'b0;
      end
      chk("rnd_valid", out_valid, m_vld);
      if (m_vld) begin
        chk("rnd_y", out_y, m_y);
        chk("rnd_zero", out_zero, (m_y == 8'h00));
`ifdef LOGIC_UNIT_PARITY_EN
        chk("rnd_parity", out_parity, ^m_y);
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
